// File: rtl/mem_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_seq_pkg
//  Description : Shared types and constants for the memory access sequencer.
//                Contains the FSM state encoding, the phase lengths, the core
//                func codes and the store predicate.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_seq_pkg;

  // Width of the bit index / phase counter
  localparam int IDX_W = 5;

  // Lengths of the single-cycle phases
  localparam int SETUP_LEN  = 1;
  localparam int CHECK_LEN  = 1;
  localparam int COMMIT_LEN = 1;
  localparam int FIN_LEN    = 1;

  // Core func encoding: five loads followed by three stores
  localparam logic [2:0] FUNC_LB  = 3'b000;
  localparam logic [2:0] FUNC_LH  = 3'b001;
  localparam logic [2:0] FUNC_LW  = 3'b010;
  localparam logic [2:0] FUNC_LBU = 3'b011;
  localparam logic [2:0] FUNC_LHU = 3'b100;
  localparam logic [2:0] FUNC_SB  = 3'b101;
  localparam logic [2:0] FUNC_SH  = 3'b110;
  localparam logic [2:0] FUNC_SW  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ADDR   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DATA   = 3'd4,
    ST_COMMIT = 3'd5,
    ST_FIN    = 3'd6
  } state_t;

  // True for the store access types
  function automatic logic is_store(input logic [2:0] f);
    return (f == FUNC_SB) || (f == FUNC_SH) || (f == FUNC_SW);
  endfunction

  // Last bit index of each timed phase; the counter's terminal compare value
  function automatic logic [IDX_W-1:0] phase_last(input state_t s,
                                                  input int addr_bits,
                                                  input int data_bits);
    case (s)
      ST_SETUP:  return IDX_W'(SETUP_LEN - 1);
      ST_ADDR:   return IDX_W'(addr_bits - 1);
      ST_CHECK:  return IDX_W'(CHECK_LEN - 1);
      ST_DATA:   return IDX_W'(data_bits - 1);
      ST_COMMIT: return IDX_W'(COMMIT_LEN - 1);
      ST_FIN:    return IDX_W'(FIN_LEN - 1);
      default:   return '0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_sequencer_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bit_counter
//  Description : Phase bit counter with synchronous clear, count enable and
//                a terminal-count compare against a supplied value.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_counter
  import mem_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [IDX_W-1:0] tc_val,
  output logic [IDX_W-1:0] count,
  output logic             tc
);

  logic [IDX_W-1:0] cnt_d;
  logic [IDX_W-1:0] cnt_q;

  // Next count: clear wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign tc    = (cnt_q == tc_val);

endmodule
`default_nettype wire

// File: rtl/mem_access_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_sequencer
//  Description : Bit-serial load/store sequencer. Streams the address into
//                the serialiser, then either routes returned data bits to the
//                register file (loads) or streams rs2 bits in and pulses the
//                memory write (stores).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] func,
  input  logic       addr_bit,
  input  logic       rs2_bit,
  output logic [4:0] bit_idx,
  output logic [2:0] ser_func,
  output logic       ser_mode,
  output logic       ser_data_in_bit,
  input  logic       ser_data_out_bit,
  input  logic       ser_mem_misaligned,
  output logic       rd_bit,
  output logic       rd_we,
  output logic       mem_we,
  output logic       busy,
  output logic       done,
  output logic       error
);

  state_t           state_d, state_q;
  logic [2:0]       func_d, func_q;
  logic             error_d, error_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             ser_mode_d, ser_mode_q;
  logic             rd_we_d, rd_we_q;
  logic             mem_we_d, mem_we_q;

  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] cnt_tc_val;
  logic             cnt_tc;
  logic             cnt_clr;
  logic             cnt_en;

  // Every phase ends when the counter hits that phase's last index; the
  // counter restarts from zero whenever the state changes
  assign cnt_tc_val = phase_last(state_q, ADDR_BITS, DATA_BITS);
  assign cnt_clr    = (state_d != state_q);
  assign cnt_en     = (state_q != ST_IDLE);

  bit_counter u_bit_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .tc_val (cnt_tc_val),
    .count  (cnt),
    .tc     (cnt_tc)
  );

  // Next-state, latched request and output decode from the next state so
  // the phase flags are registered and line up with the state register
  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          func_d  = func;
          error_d = 1'b0;
        end
      end
      ST_SETUP: begin
        if (cnt_tc) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (cnt_tc) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (cnt_tc) begin
          if (ser_mem_misaligned) begin
            error_d = 1'b1;
            state_d = ST_FIN;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (cnt_tc) state_d = is_store(func_q) ? ST_COMMIT : ST_FIN;
      end
      ST_COMMIT: begin
        if (cnt_tc) state_d = ST_FIN;
      end
      ST_FIN: begin
        if (cnt_tc) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_FIN);
    ser_mode_d = (state_d == ST_SETUP) || (state_d == ST_ADDR);
    rd_we_d    = (state_d == ST_DATA) && !is_store(func_d);
    mem_we_d   = (state_d == ST_COMMIT);
  end

  // FSM and registered status outputs; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      func_q     <= 3'b000;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ser_mode_q <= 1'b0;
      rd_we_q    <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      func_q     <= func_d;
      error_q    <= error_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ser_mode_q <= ser_mode_d;
      rd_we_q    <= rd_we_d;
      mem_we_q   <= mem_we_d;
    end
  end

  // Serial data paths pass straight through during their phase
  always_comb begin
    ser_data_in_bit = 1'b0;
    rd_bit          = 1'b0;
    if (state_q == ST_ADDR) begin
      ser_data_in_bit = addr_bit;
    end else if (state_q == ST_DATA) begin
      if (is_store(func_q)) begin
        ser_data_in_bit = rs2_bit;
      end else begin
        rd_bit = ser_data_out_bit;
      end
    end
  end

  assign bit_idx  = cnt;
  assign ser_func = func_q;
  assign ser_mode = ser_mode_q;
  assign rd_we    = rd_we_q;
  assign mem_we   = mem_we_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_sequencer
//  Description : Self-checking bench for mem_access_sequencer with a
//                behavioural ALU / rs2 / serialiser model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_sequencer;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b011;
  localparam logic [2:0] LHU = 3'b100, SB = 3'b101, SH = 3'b110, SW = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] func = 3'b000;
  logic       addr_bit, rs2_bit, ser_data_out_bit, ser_mem_misaligned;
  logic [4:0] bit_idx;
  logic [2:0] ser_func;
  logic       ser_mode, ser_data_in_bit, rd_bit, rd_we, mem_we, busy, done, error;

  // Environment model state for the current request
  logic [11:0] m_addr = '0;
  logic [31:0] m_word = '0;
  logic        m_mis  = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_sequencer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .func               (func),
    .addr_bit           (addr_bit),
    .rs2_bit            (rs2_bit),
    .bit_idx            (bit_idx),
    .ser_func           (ser_func),
    .ser_mode           (ser_mode),
    .ser_data_in_bit    (ser_data_in_bit),
    .ser_data_out_bit   (ser_data_out_bit),
    .ser_mem_misaligned (ser_mem_misaligned),
    .rd_bit             (rd_bit),
    .rd_we              (rd_we),
    .mem_we             (mem_we),
    .busy               (busy),
    .done               (done),
    .error              (error)
  );

  // ALU, rs2 and serialiser streams indexed by the sequencer's bitPos
  assign addr_bit           = (bit_idx < 5'd12) ? m_addr[bit_idx[3:0]] : 1'b0;
  assign rs2_bit            = m_word[bit_idx];
  assign ser_data_out_bit   = m_word[bit_idx];
  assign ser_mem_misaligned = m_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic ref_store(input logic [2:0] f);
    return f >= SB;
  endfunction

  function automatic logic ref_mis(input logic [2:0] f, input logic [11:0] a);
    case (f)
      LH, LHU, SH: return a[0];
      LW, SW:      return a[1:0] != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] all_outs();
    return {bit_idx, ser_func, ser_mode, ser_data_in_bit, rd_bit, rd_we,
            mem_we, busy, done, error};
  endfunction

  // One access. Called at a negedge; start is raised at once. Cycle c is the
  // c-th cycle after the edge that samples start. hold keeps start high,
  // chain raises start with nfunc in the done cycle, abort_c pulses reset.
  task automatic do_access(input logic [2:0] f, input logic [11:0] a,
                           input logic [31:0] w, input bit hold, input bit chain,
                           input logic [2:0] nfunc, input int abort_c);
    bit          st, mis, ld;
    int          done_exp, c, done_at, done_cnt, rdwe_cnt, rdwe_bad;
    int          memwe_cnt, memwe_at, addr_n, idx_bad, ghost_done;
    logic [31:0] rd_acc, st_acc;
    logic [12:0] addr_acc;
    st  = ref_store(f);
    mis = ref_mis(f, a);
    ld  = !st && !mis;
    done_exp = mis ? 15 : (st ? 48 : 47);
    c = 0; done_at = -1; done_cnt = 0; rdwe_cnt = 0; rdwe_bad = 0;
    memwe_cnt = 0; memwe_at = -1; addr_n = 0; idx_bad = 0; ghost_done = 0;
    rd_acc = '0; st_acc = '0; addr_acc = '0;
    m_addr = a; m_word = w; m_mis = mis;
    func = f; start = 1'b1;
    while (1) begin
      @(negedge clk);
      c++;
      if (c == 1 && !hold) start = 1'b0;
      if (c == 1) begin
        check("busy_rise", busy, 1'b1);
        check("ser_func", ser_func, f);
      end
      if (abort_c != 0 && c == abort_c) begin
        check("abort_idx", bit_idx, 32'd10);
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check("abort_outs", all_outs(), 16'h0000);
        repeat (3) begin
          @(negedge clk);
          if (done || busy) ghost_done++;
        end
        check("abort_quiet", ghost_done, 0);
        rst_n = 1'b1;
        return;
      end
      if (ser_mode && addr_n < 13) begin
        addr_acc[addr_n] = ser_data_in_bit;
        addr_n++;
      end
      if (!mis && c >= 15 && c <= 46) begin
        if (bit_idx != 5'(c - 15)) idx_bad++;
        if (st) st_acc[c-15] = ser_data_in_bit;
      end
      if (rd_we) begin
        rdwe_cnt++;
        if (c < 15 || c > 46) rdwe_bad++;
        rd_acc[bit_idx] = rd_bit;
      end
      if (mem_we) begin
        memwe_cnt++;
        memwe_at = c;
        check("mem_data", st_acc, w);
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c;
          check("err_at_done", error, mis);
          if (chain) begin
            start = 1'b1;
            func  = nfunc;
          end
        end
      end
      if (done_at >= 0 && c == done_at + 1) begin
        check("busy_fall", busy, 1'b0);
        check("err_held", error, mis);
        break;
      end
      if (c >= 70) begin
        check("done_timeout", done_at, done_exp);
        break;
      end
    end
    check("done_cycle", done_at, done_exp);
    check("done_count", done_cnt, 1);
    check("addr_len", addr_n, 13);
    check("addr_stream", addr_acc, {a, 1'b0});
    check("rd_we_count", rdwe_cnt, ld ? 32 : 0);
    check("rd_we_window", rdwe_bad, 0);
    check("bit_idx_data", idx_bad, 0);
    if (ld) check("rd_word", rd_acc, w);
    check("mem_we_count", memwe_cnt, (st && !mis) ? 1 : 0);
    if (st && !mis) check("mem_we_cycle", memwe_at, 47);
  endtask

  initial begin
    logic [2:0] rf;
    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outs", all_outs(), 16'h0000);

    do_access(LW,  12'h004, 32'h0000_8006, 0, 0, LB, 0);
    do_access(SW,  12'h000, 32'hF000_000F, 0, 0, LB, 0);
    do_access(LH,  12'h001, $urandom, 0, 0, LB, 0);
    do_access(LB,  12'h003, $urandom, 0, 1, LHU, 0);
    do_access(LHU, 12'h002, $urandom, 0, 0, LB, 0);
    do_access(SH,  12'h002, $urandom, 0, 0, LB, 25);
    @(negedge clk);
    do_access(SB,  12'h002, $urandom, 0, 0, LB, 0);
    do_access(LBU, 12'($urandom), $urandom, 1, 0, LB, 0);
    do_access(LW,  12'h008, $urandom, 0, 0, LB, 0);

    for (int i = 0; i < 20; i++) begin
      rf = 3'($urandom_range(0, 7));
      do_access(rf, 12'($urandom), $urandom, 0, 0, LB, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
